pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Controls the PLL from the consumer side. Drives the PLL reset, watches
//  its extlock output, and releases the system reset only after lock has
//  been stable for a programmed time. Retries on lock timeout and on loss
//  of lock. Sits between the board reset pin and the PLL wrapper / core
//  reset tree. Runs on the free-running reference clock, never on the PLL
//  output.
// PARAMETERS
//  RST_CYCLES     16    cycles pll_rst is held high per reset attempt (>=2)
//  LOCK_TIMEOUT   4800  max cycles to wait for lock before retrying (200us @ 24MHz)
//  STABLE_CYCLES  256   consecutive synced-lock cycles required before release
//  CNT_W          16    width of the shared phase counter; must hold max parameter
//  RETRY_W        8     width of the retry counter
// PORTS
//  refclk      in   1        free-running reference clock (24 MHz)
//  reset       in   1        asynchronous, active-high block reset
//  extlock     in   1        PLL lock flag; asynchronous to refclk
//  relock_req  in   1        1-cycle pulse: software-forced PLL re-lock
//  pll_rst     out  1        reset to the PLL (pllreset), active high
//  sys_rst     out  1        core reset, active high; consumer resyncs per domain
//  ready       out  1        high while in RUN
//  lock_lost   out  1        1-cycle pulse: lock dropped while in RUN
//  timeout     out  1        1-cycle pulse: WAIT_LOCK expired
//  retry_cnt   out  RETRY_W  count of timeouts plus lock losses; saturates at all-ones
// BEHAVIOUR
//  - All outputs are registered. While reset is high: state=RST, cnt=0,
//    sync=00, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, timeout=0,
//    retry_cnt=0.
//  - extlock passes through a 2-FF synchroniser to give lock_s. The FSM
//    uses only lock_s.
//  - RST: pll_rst=1 and cnt increments. When cnt==RST_CYCLES-1, go to
//    WAIT_LOCK and clear cnt. pll_rst is high for exactly RST_CYCLES cycles.
//  - WAIT_LOCK: pll_rst=0.
//    - If lock_s=1, go to STABLE and clear cnt.
//    - Otherwise, if cnt==LOCK_TIMEOUT-1, go to RST, pulse timeout, and
//      increment retry_cnt.
//  - STABLE:
//    - If lock_s=0, go back to WAIT_LOCK and clear cnt. This is a glitch
//      case: no PLL reset and no retry count.
//    - Otherwise, when cnt==STABLE_CYCLES-1, go to RUN.
//  - RUN: sys_rst=0 and ready=1. These change on the same edge the state
//    enters RUN. If lock_s=0, go to RST, clear cnt, pulse lock_lost, and
//    increment retry_cnt.
//  - sys_rst=1 and ready=0 in every state except RUN.
//  - Latency: extlock rising in WAIT_LOCK makes sys_rst fall exactly
//    STABLE_CYCLES+3 cycles later. That is 2 sync cycles, 1 cycle to enter
//    STABLE, then STABLE_CYCLES.
//  - relock_req in WAIT_LOCK, STABLE or RUN goes to RST and clears cnt, with
//    no retry_cnt change. It is ignored in RST, and the RST count is not
//    restarted.
//  - Simultaneous lock loss and relock_req in RUN is treated as a lock
//    loss: lock_lost pulses and retry_cnt increments.
//  - A timeout on the same cycle as lock_s rising in WAIT_LOCK: lock wins,
//    go to STABLE.
//  - retry_cnt saturates at 2^RETRY_W-1 and is cleared only by reset.
//  - Asserting reset mid-sequence returns to the reset values immediately,
//    including pll_rst=1 and sys_rst=1 asynchronously.
//  - Unreachable state encodings recover to RST.
// TESTING (bench params RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8)
//  1. Release reset with extlock=1 held -> pll_rst high 4 cycles; sys_rst
//     falls 11 cycles after WAIT_LOCK entry; ready=1; retry_cnt=0.
//  2. extlock held 0 -> timeout pulses every 24 cycles (4 RST + 20 WAIT);
//     retry_cnt counts 1,2,3...
//  3. In STABLE, drop extlock for 1 cycle at stable count 5 -> back to
//     WAIT_LOCK, no pll_rst; release is delayed by the full 8+3 cycles
//     from re-lock.
//  4. In RUN, drop extlock -> lock_lost pulse 3 cycles later, same edge as
//     sys_rst=1 and ready=0; pll_rst high 4 cycles; retry_cnt +1.
//  5. relock_req in RUN -> RST next edge, retry_cnt unchanged. relock_req
//     during RST -> pll_rst still exactly 4 cycles.
//  6. Force 300 lock losses with RETRY_W=8 -> retry_cnt stops at 255.
//     Assert reset mid-STABLE -> all outputs at reset values without
//     waiting for a clock edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: holds the PLL in reset, waits for a synchronised lock,
// requires lock to stay stable for a programmed time, then releases the
// core reset. Retries on lock timeout and on loss of lock. Runs on refclk.
//
// Ports:
//   refclk      free-running reference clock
//   reset       asynchronous, active-high block reset
//   extlock     PLL lock flag, asynchronous to refclk
//   relock_req  single-cycle software request to re-lock the PLL
//   pll_rst     reset to the PLL, active high
//   sys_rst     core reset, active high (low only in RUN)
//   ready       high while in RUN
//   lock_lost   single-cycle pulse: lock dropped while in RUN
//   timeout     single-cycle pulse: lock wait expired
//   retry_cnt   timeouts plus lock losses, saturating
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4800,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned RETRY_W       = 8
) (
  input  logic               refclk,
  input  logic               reset,
  input  logic               extlock,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic               timeout,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST       = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         sync_q;
  logic               lock_s;
  logic               retry_inc;
  logic               pll_rst_nxt, sys_rst_nxt, ready_nxt;
  logic               lock_lost_nxt, timeout_nxt;
  logic [RETRY_W-1:0] retry_nxt;

  // Two-flop synchroniser for the asynchronous lock flag
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], extlock};
  end

  assign lock_s = sync_q[1];

  // State, phase counter and registered outputs
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state     <= ST_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      timeout   <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pll_rst   <= pll_rst_nxt;
      sys_rst   <= sys_rst_nxt;
      ready     <= ready_nxt;
      lock_lost <= lock_lost_nxt;
      timeout   <= timeout_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // Next state; outputs decoded from the next state so they are registered
  // and change on the same edge as the state
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + CNT_W'(1);
    timeout_nxt   = 1'b0;
    lock_lost_nxt = 1'b0;
    retry_inc     = 1'b0;
    retry_nxt     = retry_cnt;

    case (state)
      ST_RST: begin
        // relock_req is ignored here so the PLL reset width is never stretched
        if (cnt == RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (relock_req) begin
          state_nxt = ST_RST;
          cnt_nxt   = '0;
        end else if (lock_s) begin
          // lock beats a coincident timeout
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = ST_RST;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
          retry_inc   = 1'b1;
        end
      end
      ST_STABLE: begin
        if (relock_req) begin
          state_nxt = ST_RST;
          cnt_nxt   = '0;
        end else if (!lock_s) begin
          // glitch: restart the lock wait without resetting the PLL
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        // lock loss takes precedence over a coincident relock_req
        if (!lock_s) begin
          state_nxt     = ST_RST;
          lock_lost_nxt = 1'b1;
          retry_inc     = 1'b1;
        end else if (relock_req) begin
          state_nxt = ST_RST;
        end
      end
      default: begin
        state_nxt = ST_RST;
        cnt_nxt   = '0;
      end
    endcase

    if (retry_inc && (retry_cnt != '1)) retry_nxt = retry_cnt + RETRY_W'(1);

    pll_rst_nxt = (state_nxt == ST_RST);
    sys_rst_nxt = (state_nxt != ST_RUN);
    ready_nxt   = (state_nxt == ST_RUN);
  end

endmodule
